// File: rtl/scaler_h_ctrl_pkg.sv
// Shared types and constants for the horizontal scaler control sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package scaler_h_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_FLUSH  = 2'd2
    } state_t;

    localparam int ERR_IN_W  = 0;
    localparam int ERR_OUT_W = 1;
    localparam int ERR_LINES = 2;
    localparam int ERR_WDOG  = 3;

    // 1.000 in unsigned 4.12 fixed point
    localparam int STEP_ONE = 4096;

endpackage

// File: rtl/scaler_h_ctrl_linemeas.sv
// Line geometry snooper for one sync stream: line width, reference width, line count.
// Latency: width/count registers update on the edge that closes a line; width_err is combinational on that cycle.
// Backpressure: none, observes the stream only.
module scaler_h_ctrl_linemeas
    import scaler_h_ctrl_pkg::*;
#(
    parameter int LINE_SIZE_MAX   = 4096,
    parameter int FRAME_LINES_MAX = 4096,
    localparam int CW = $clog2(LINE_SIZE_MAX + 1),
    localparam int LW = $clog2(FRAME_LINES_MAX + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          clr,
    input  logic          de,
    input  logic          hs,
    input  logic          vs,
    output logic          vs_rise,
    output logic          vs_fall,
    output logic          act_rise,
    output logic [CW-1:0] ref_w,
    output logic [LW-1:0] lines,
    output logic          width_err
);

    logic          de_q;
    logic          hs_q;
    logic          vs_q;
    logic [CW-1:0] cnt;
    logic          ref_vld;
    logic          hs_rise;
    logic          line_close;

    assign hs_rise  = hs & ~hs_q;
    assign vs_rise  = vs & ~vs_q;
    assign vs_fall  = ~vs & vs_q;
    assign act_rise = (de & ~de_q) | hs_rise;

    // A line closes on hs rise, or on vs rise if the line never saw its hs
    assign line_close = en & (hs_rise | vs_rise) & (cnt != '0);
    assign width_err  = line_close & ref_vld & (cnt != ref_w);

    // Previous sync values for edge detection, tracked regardless of frame state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            de_q <= 1'b0;
            hs_q <= 1'b0;
            vs_q <= 1'b0;
        end else begin
            de_q <= de;
            hs_q <= hs;
            vs_q <= vs;
        end
    end

    // Width counter, first-line reference width and saturating line counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            ref_w   <= '0;
            ref_vld <= 1'b0;
            lines   <= '0;
        end else if (clr) begin
            cnt     <= '0;
            ref_w   <= '0;
            ref_vld <= 1'b0;
            lines   <= '0;
        end else if (line_close) begin
            cnt <= '0;
            if (!ref_vld) begin
                ref_w   <= cnt;
                ref_vld <= 1'b1;
            end
            if (lines != LW'(FRAME_LINES_MAX)) begin
                lines <= lines + 1'b1;
            end
        end else if (en && de && !hs && (cnt != CW'(LINE_SIZE_MAX))) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/scaler_h_ctrl.sv
// Horizontal scaler control: applies scale_step only between frames, measures frame geometry, flags errors.
// Latency: IDLE step write 1 cycle; stats 1 cycle after the output frame end is seen.
// Backpressure: none; config writes always accepted (held pending during a frame). Watchdog: SCALER_H_CTRL_WDOG_EN.
module scaler_h_ctrl
    import scaler_h_ctrl_pkg::*;
#(
    parameter int STEP_WIDTH      = 16,
    parameter int STEP_DEFAULT    = STEP_ONE,
    parameter int LINE_SIZE_MAX   = 4096,
    parameter int FRAME_LINES_MAX = 4096,
    parameter int WDOG_CYCLES     = 65536,
    localparam int CW = $clog2(LINE_SIZE_MAX + 1),
    localparam int LW = $clog2(FRAME_LINES_MAX + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [STEP_WIDTH-1:0] cfg_step_i,
    input  logic                  cfg_wr_i,
    output logic                  cfg_pend_o,
    input  logic                  err_clr_i,
    input  logic                  in_de_i,
    input  logic                  in_hs_i,
    input  logic                  in_vs_i,
    input  logic                  out_de_i,
    input  logic                  out_hs_i,
    input  logic                  out_vs_i,
    output logic [STEP_WIDTH-1:0] scale_step_o,
    output logic                  frame_act_o,
    output logic                  stat_vld_o,
    output logic [CW-1:0]         stat_in_w_o,
    output logic [CW-1:0]         stat_out_w_o,
    output logic [LW-1:0]         stat_lines_o,
    output logic [3:0]            err_o
);

    state_t                  state;
    state_t                  state_nxt;
    logic                    frame_close;
    logic                    out_done;
    logic                    wdog_hit;
    logic [STEP_WIDTH-1:0]   pend_step;
    logic [3:0]              err_set;

    logic                    in_vs_rise;
    logic                    in_vs_fall;
    logic                    out_vs_rise;
    logic                    out_act_rise;
    logic                    unused_in_act;
    logic                    unused_out_vs_fall;
    logic [CW-1:0]           in_ref_w;
    logic [CW-1:0]           out_ref_w;
    logic [LW-1:0]           in_lines;
    logic [LW-1:0]           out_lines;
    logic                    in_w_err;
    logic                    out_w_err;

    assign frame_act_o = (state != ST_IDLE);

    scaler_h_ctrl_linemeas #(
        .LINE_SIZE_MAX   (LINE_SIZE_MAX),
        .FRAME_LINES_MAX (FRAME_LINES_MAX)
    ) u_in_meas (
        .clk       (clk),
        .rst       (rst),
        .en        (frame_act_o),
        .clr       (frame_close),
        .de        (in_de_i),
        .hs        (in_hs_i),
        .vs        (in_vs_i),
        .vs_rise   (in_vs_rise),
        .vs_fall   (in_vs_fall),
        .act_rise  (unused_in_act),
        .ref_w     (in_ref_w),
        .lines     (in_lines),
        .width_err (in_w_err)
    );

    scaler_h_ctrl_linemeas #(
        .LINE_SIZE_MAX   (LINE_SIZE_MAX),
        .FRAME_LINES_MAX (FRAME_LINES_MAX)
    ) u_out_meas (
        .clk       (clk),
        .rst       (rst),
        .en        (frame_act_o),
        .clr       (frame_close),
        .de        (out_de_i),
        .hs        (out_hs_i),
        .vs        (out_vs_i),
        .vs_rise   (out_vs_rise),
        .vs_fall   (unused_out_vs_fall),
        .act_rise  (out_act_rise),
        .ref_w     (out_ref_w),
        .lines     (out_lines),
        .width_err (out_w_err)
    );

`ifdef SCALER_H_CTRL_WDOG_EN
    localparam int WW = $clog2(WDOG_CYCLES + 1);
    logic [WW-1:0] wdog_cnt;

    assign wdog_hit = frame_act_o & (wdog_cnt == WW'(WDOG_CYCLES));

    // Cycles of output silence inside a frame; any output de/hs activity restarts it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wdog_cnt <= '0;
        end else if (!frame_act_o || out_act_rise || wdog_hit) begin
            wdog_cnt <= '0;
        end else begin
            wdog_cnt <= wdog_cnt + 1'b1;
        end
    end
`else
    logic unused_wdog;
    assign wdog_hit    = 1'b0;
    assign unused_wdog = out_act_rise | (WDOG_CYCLES == 0);
`endif

    // Frame state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state; frame_close marks the single edge that ends a frame
    always_comb begin
        state_nxt   = state;
        frame_close = 1'b0;
        case (state)
            ST_IDLE: begin
                if (in_vs_fall) begin
                    state_nxt = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (wdog_hit) begin
                    state_nxt   = ST_IDLE;
                    frame_close = 1'b1;
                end else if (in_vs_rise) begin
                    state_nxt = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (out_done || wdog_hit) begin
                    state_nxt   = ST_IDLE;
                    frame_close = 1'b1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Output frame end seen; it may arrive before the input side reaches FLUSH
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_done <= 1'b0;
        end else if ((state == ST_IDLE) && in_vs_fall) begin
            out_done <= 1'b0;
        end else if (frame_close) begin
            out_done <= 1'b0;
        end else if (frame_act_o && out_vs_rise) begin
            out_done <= 1'b1;
        end
    end

    // Step register: direct update between frames, otherwise held pending until frame close
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scale_step_o <= STEP_WIDTH'(STEP_DEFAULT);
            pend_step    <= '0;
            cfg_pend_o   <= 1'b0;
        end else if (frame_close) begin
            if (cfg_wr_i) begin
                scale_step_o <= cfg_step_i;
            end else if (cfg_pend_o) begin
                scale_step_o <= pend_step;
            end
            cfg_pend_o <= 1'b0;
        end else if (cfg_wr_i) begin
            if (state == ST_IDLE) begin
                scale_step_o <= cfg_step_i;
            end else begin
                pend_step  <= cfg_step_i;
                cfg_pend_o <= 1'b1;
            end
        end
    end

    // Error conditions raised this cycle
    always_comb begin
        err_set            = '0;
        err_set[ERR_IN_W]  = in_w_err;
        err_set[ERR_OUT_W] = out_w_err;
        err_set[ERR_LINES] = frame_close & (in_lines != out_lines);
        err_set[ERR_WDOG]  = wdog_hit;
    end

    // Sticky error bits; a new error wins over a clear in the same cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_o <= '0;
        end else begin
            err_o <= (err_clr_i ? 4'b0000 : err_o) | err_set;
        end
    end

    // Publish the frame's geometry on the closing edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_vld_o   <= 1'b0;
            stat_in_w_o  <= '0;
            stat_out_w_o <= '0;
            stat_lines_o <= '0;
        end else begin
            stat_vld_o <= frame_close;
            if (frame_close) begin
                stat_in_w_o  <= in_ref_w;
                stat_out_w_o <= out_ref_w;
                stat_lines_o <= in_lines;
            end
        end
    end

endmodule

// File: tb/tb_scaler_h_ctrl.sv
// Bench for scaler_h_ctrl: directed frames, queue-based reference model checked every cycle.
// Latency: model predicts outputs one clock after the inputs it observes.
// Backpressure: n/a.
module tb_scaler_h_ctrl;

    localparam int LMAX = 4096;
    localparam int FMAX = 4096;
    localparam int WDOG = 1000;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] cfg_step;
    logic        cfg_wr;
    logic        cfg_pend;
    logic        err_clr;
    logic        in_de, in_hs, in_vs;
    logic        out_de, out_hs, out_vs;
    logic [15:0] scale_step;
    logic        frame_act;
    logic        stat_vld;
    logic [12:0] stat_in_w;
    logic [12:0] stat_out_w;
    logic [12:0] stat_lines;
    logic [3:0]  err;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    scaler_h_ctrl #(
        .WDOG_CYCLES (WDOG)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cfg_step_i   (cfg_step),
        .cfg_wr_i     (cfg_wr),
        .cfg_pend_o   (cfg_pend),
        .err_clr_i    (err_clr),
        .in_de_i      (in_de),
        .in_hs_i      (in_hs),
        .in_vs_i      (in_vs),
        .out_de_i     (out_de),
        .out_hs_i     (out_hs),
        .out_vs_i     (out_vs),
        .scale_step_o (scale_step),
        .frame_act_o  (frame_act),
        .stat_vld_o   (stat_vld),
        .stat_in_w_o  (stat_in_w),
        .stat_out_w_o (stat_out_w),
        .stat_lines_o (stat_lines),
        .err_o        (err)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int  m_phase;            // 0 between frames, 1 input frame running, 2 waiting for output frame end
    bit  m_done;
    int  m_step, m_pend_val;
    bit  m_pend;
    bit [3:0] m_err;
    bit  m_vld;
    int  m_in_w, m_out_w, m_lines;
    int  icnt, ocnt, m_wd;
    int  iq[$];              // widths of closed input lines in this frame
    int  oq[$];              // widths of closed output lines in this frame
    bit  p_ide, p_ihs, p_ivs, p_ode, p_ohs, p_ovs;

    int  cap_n = 0;
    int  cap_in_w, cap_out_w, cap_lines;

    task automatic model_reset();
        m_phase = 0; m_done = 0; m_step = 4096; m_pend_val = 0; m_pend = 0;
        m_err = 0; m_vld = 0; m_in_w = 0; m_out_w = 0; m_lines = 0;
        icnt = 0; ocnt = 0; m_wd = 0;
        iq.delete(); oq.delete();
        p_ide = 0; p_ihs = 0; p_ivs = 0; p_ode = 0; p_ohs = 0; p_ovs = 0;
    endtask

    task automatic model_step();
        bit act, ivr, ivf, ovr, ihr, ohr, odr, close, wd_hit;
        bit [3:0] set;
        int nin, nout;
        act = (m_phase != 0);
        ivr = in_vs & !p_ivs;   ivf = !in_vs & p_ivs;
        ovr = out_vs & !p_ovs;  ihr = in_hs & !p_ihs;
        ohr = out_hs & !p_ohs;  odr = out_de & !p_ode;
        set = 4'b0000;
        if (act) begin
            if ((ihr || ivr) && icnt > 0) begin
                if (iq.size() > 0 && icnt != iq[0]) set[0] = 1'b1;
                iq.push_back(icnt);
                icnt = 0;
            end else if (in_de && !in_hs && icnt < LMAX) icnt++;
            if ((ohr || ovr) && ocnt > 0) begin
                if (oq.size() > 0 && ocnt != oq[0]) set[1] = 1'b1;
                oq.push_back(ocnt);
                ocnt = 0;
            end else if (out_de && !out_hs && ocnt < LMAX) ocnt++;
        end
`ifdef SCALER_H_CTRL_WDOG_EN
        wd_hit = act && (m_wd == WDOG);
        if (!act || odr || ohr || wd_hit) m_wd = 0; else m_wd++;
`else
        wd_hit = 1'b0;
`endif
        set[3] = wd_hit;
        close = ((m_phase == 2) && m_done) || wd_hit;
        m_vld = close;
        if (close) begin
            nin  = (iq.size() > FMAX) ? FMAX : iq.size();
            nout = (oq.size() > FMAX) ? FMAX : oq.size();
            m_in_w  = (iq.size() > 0) ? iq[0] : 0;
            m_out_w = (oq.size() > 0) ? oq[0] : 0;
            m_lines = nin;
            if (nin != nout) set[2] = 1'b1;
            iq.delete(); oq.delete(); icnt = 0; ocnt = 0;
            if (cfg_wr) m_step = int'(cfg_step);
            else if (m_pend) m_step = m_pend_val;
            m_pend = 0;
        end else if (cfg_wr) begin
            if (m_phase == 0) m_step = int'(cfg_step);
            else begin m_pend_val = int'(cfg_step); m_pend = 1; end
        end
        m_err = (err_clr ? 4'b0000 : m_err) | set;
        if (m_phase == 0 && ivf) m_done = 0;
        else if (close) m_done = 0;
        else if (act && ovr) m_done = 1;
        if (m_phase == 0) begin
            if (ivf) m_phase = 1;
        end else if (close) m_phase = 0;
        else if (m_phase == 1 && ivr) m_phase = 2;
        p_ide = in_de; p_ihs = in_hs; p_ivs = in_vs;
        p_ode = out_de; p_ohs = out_hs; p_ovs = out_vs;
    endtask

    // Compare every cycle, mid-period, then advance the model with this cycle's inputs
    always @(negedge clk) begin
        if (rst) model_reset();
        chk("scale_step", int'(scale_step), m_step);
        chk("cfg_pend",   int'(cfg_pend),   int'(m_pend));
        chk("frame_act",  int'(frame_act),  int'(m_phase != 0));
        chk("stat_vld",   int'(stat_vld),   int'(m_vld));
        chk("stat_in_w",  int'(stat_in_w),  m_in_w);
        chk("stat_out_w", int'(stat_out_w), m_out_w);
        chk("stat_lines", int'(stat_lines), m_lines);
        chk("err",        int'(err),        int'(m_err));
        if (stat_vld) begin
            cap_n++;
            cap_in_w  = int'(stat_in_w);
            cap_out_w = int'(stat_out_w);
            cap_lines = int'(stat_lines);
        end
        if (!rst) model_step();
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write(input int v);
        cfg_step = 16'(v);
        cfg_wr   = 1'b1;
        tick();
        cfg_wr   = 1'b0;
    endtask

    // One line: wo < 0 leaves the output stream completely untouched
    task automatic drive_line(input int wi, input int wo, input bit tail_hs);
        int span;
        span = ((wi > wo) ? wi : wo) + 1;
        in_hs = 1'b0;
        if (wo >= 0) out_hs = 1'b0;
        for (int c = 0; c < span; c++) begin
            in_de  = (c < wi);
            out_de = (c < wo);
            tick();
        end
        in_de  = 1'b0;
        out_de = 1'b0;
        if (tail_hs) begin
            in_hs = 1'b1;
            if (wo >= 0) out_hs = 1'b1;
            repeat (3) tick();
        end
    endtask

    task automatic run_frame(input int wi, input int wo, input int nl, input int short_line,
                             input int short_w, input int drop_line, input bit vs_close);
        in_vs  = 1'b0;
        out_vs = 1'b0;
        repeat (2) tick();
        for (int l = 0; l < nl; l++) begin
            drive_line((l == short_line) ? short_w : wi, (l == drop_line) ? 0 : wo,
                       !(vs_close && l == nl - 1));
        end
        in_vs = 1'b1;
        repeat (5) tick();
        out_vs = 1'b1;
        tick();
        in_hs  = 1'b1;
        out_hs = 1'b1;
        repeat (4) tick();
    endtask

    task automatic clear_err();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
    endtask

    initial begin
        int n0;
        rst = 1'b1; cfg_step = '0; cfg_wr = 1'b0; err_clr = 1'b0;
        in_de = 1'b0; in_hs = 1'b1; in_vs = 1'b1;
        out_de = 1'b0; out_hs = 1'b1; out_vs = 1'b1;
        repeat (3) tick();
        chk("reset_step", int'(scale_step), 4096);
        chk("reset_err", int'(err), 0);
        rst = 1'b0;
        repeat (4) tick();

        // Plain 25x25 frame, default step
        n0 = cap_n;
        run_frame(25, 25, 25, -1, 0, -1, 1'b0);
        chk("f1_pulses", cap_n - n0, 1);
        chk("f1_in_w", cap_in_w, 25);
        chk("f1_out_w", cap_out_w, 25);
        chk("f1_lines", cap_lines, 25);
        chk("f1_err", int'(err), 0);

        // Write between frames takes effect next cycle; last lines close on vs
        write(2703);
        chk("idle_wr_step", int'(scale_step), 2703);
        n0 = cap_n;
        run_frame(25, 37, 25, -1, 0, -1, 1'b1);
        chk("f2_pulses", cap_n - n0, 1);
        chk("f2_out_w", cap_out_w, 37);
        chk("f2_lines", cap_lines, 25);
        chk("f2_err", int'(err), 0);

        // Writes during a frame stay pending until the frame closes, last one wins
        write(4096);
        fork
            run_frame(25, 25, 25, -1, 0, -1, 1'b0);
            begin
                repeat (40) tick();
                write(2703);
                chk("mid_pend", int'(cfg_pend), 1);
                repeat (20) tick();
                write(3000);
                for (int i = 0; i < 3000 && !in_vs; i++) tick();
                repeat (2) tick();
                chk("flush_act", int'(frame_act), 1);
                chk("flush_pend", int'(cfg_pend), 1);
                chk("flush_step", int'(scale_step), 4096);
            end
        join
        chk("f3_step", int'(scale_step), 3000);
        chk("f3_pend", int'(cfg_pend), 0);

        // Short input line sets the sticky input-width error
        run_frame(25, 25, 25, 7, 24, -1, 1'b0);
        chk("f4_err", int'(err), 1);
        chk("f4_in_w", cap_in_w, 25);
        clear_err();
        chk("f4_clr", int'(err), 0);

        // Missing output line: line-count mismatch at frame close
        run_frame(25, 25, 25, -1, 0, 10, 1'b0);
        chk("f5_err", int'(err), 4);
        chk("f5_lines", cap_lines, 25);
        clear_err();

        // Reset in the middle of a frame with a write pending
        in_vs = 1'b0; out_vs = 1'b0;
        repeat (2) tick();
        for (int l = 0; l < 3; l++) drive_line(25, 25, 1'b1);
        write(1234);
        chk("abort_pend", int'(cfg_pend), 1);
        in_hs = 1'b0; out_hs = 1'b0; in_de = 1'b1; out_de = 1'b1;
        repeat (10) tick();
        rst = 1'b1;
        #2;
        chk("abort_rst_step", int'(scale_step), 4096);
        chk("abort_rst_pend", int'(cfg_pend), 0);
        chk("abort_rst_act", int'(frame_act), 0);
        tick();
        rst = 1'b0;
        repeat (10) tick();
        in_de = 1'b0; out_de = 1'b0; in_hs = 1'b1; out_hs = 1'b1;
        repeat (3) tick();
        in_vs = 1'b1; out_vs = 1'b1;
        repeat (10) tick();
        n0 = cap_n;
        run_frame(25, 25, 25, -1, 0, -1, 1'b0);
        chk("f6_pulses", cap_n - n0, 1);
        chk("f6_lines", cap_lines, 25);
        chk("f6_err", int'(err), 0);
        chk("f6_step", int'(scale_step), 4096);

        // Output stream silent for the whole frame
        in_vs = 1'b0;
        repeat (2) tick();
        drive_line(25, -1, 1'b1);
        write(777);
        drive_line(25, -1, 1'b1);
        drive_line(25, -1, 1'b1);
        in_vs = 1'b1;
`ifdef SCALER_H_CTRL_WDOG_EN
        for (int i = 0; i < 1500 && frame_act; i++) tick();
        chk("wdog_idle", int'(frame_act), 0);
        chk("wdog_err3", int'(err[3]), 1);
        chk("wdog_step", int'(scale_step), 777);
        chk("wdog_pend", int'(cfg_pend), 0);
`else
        repeat (1100) tick();
        chk("nowdog_act", int'(frame_act), 1);
        chk("nowdog_err3", int'(err[3]), 0);
        chk("nowdog_step", int'(scale_step), 4096);
        out_vs = 1'b0;
        tick();
        out_vs = 1'b1;
        repeat (3) tick();
        chk("nowdog_idle", int'(frame_act), 0);
        chk("nowdog_step_applied", int'(scale_step), 777);
`endif
        repeat (5) tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
